// File: rtl/mm_job_seq_pkg.sv
// Shared definitions for the matrix-multiply job sequencer: state encoding and width helpers.
package mm_job_seq_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoadA   = 3'd1,
    StLoadB   = 3'd2,
    StStart   = 3'd3,
    StCompute = 3'd4,
    StDrain   = 3'd5
  } state_e;

  function automatic int unsigned aw_width(input int unsigned dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  function automatic int unsigned cw_width(input int unsigned dim, input int unsigned dw);
    return 2 * dw + $clog2(dim);
  endfunction

endpackage

// File: rtl/mm_skid_buf.sv
// Two-entry skid buffer: registered head, simultaneous push/pop keeps occupancy unchanged.
module mm_skid_buf #(
  parameter int unsigned W = 17
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem0_q, mem1_q;
  logic         pop_ok, push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = mem0_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem0_q <= '0;
      mem1_q <= '0;
      count  <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b10: begin
          if (count == 2'd0) mem0_q <= push_data;
          else               mem1_q <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          mem0_q <= mem1_q;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            mem0_q <= push_data;
          end else begin
            mem0_q <= mem1_q;
            mem1_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mm_job_seq.sv
// Job sequencer: loads A and B, starts the engine, waits for done, then drains C as a stream.
module mm_job_seq import mm_job_seq_pkg::*; #(
  parameter int unsigned DIM = 8,
  parameter int unsigned DW  = 8,
  parameter int unsigned AW  = aw_width(DIM),
  parameter int unsigned CW  = cw_width(DIM, DW),
  parameter int unsigned TMO = DIM * DIM * DIM + 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          A_wen,
  output logic          B_wen,
  output logic [AW-1:0] wr_i,
  output logic [AW-1:0] wr_j,
  output logic [DW-1:0] wr_data,
  output logic          load_mem,
  output logic          start,
  input  logic          done,
  output logic          C_ren,
  output logic [AW-1:0] C_ri,
  output logic [AW-1:0] C_rj,
  input  logic [CW-1:0] C_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_data,
  output logic          busy,
  output logic          err
);

  localparam int unsigned   TW       = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [AW-1:0] Last     = AW'(DIM - 1);
  localparam logic [TW-1:0] TmoLast  = TW'(TMO - 1);

  state_e        state;
  logic [AW-1:0] i_q, j_q, i_nxt, j_nxt;
  logic [TW-1:0] tmo_q;
  logic          in_flight_q, all_issued_q, err_q;
  logic [1:0]    occ;
  logic [2:0]    pending;
  logic          beat, pop, issue, ij_last, drain_done;

  assign cmd_ready = (state == StIdle);
  assign in_ready  = (state == StLoadA) || (state == StLoadB);
  assign load_mem  = in_ready;
  assign start     = (state == StStart);
  assign busy      = (state != StIdle);
  assign err       = err_q;
  assign beat      = in_valid && in_ready;
  assign A_wen     = beat && (state == StLoadA);
  assign B_wen     = beat && (state == StLoadB);
  assign wr_i      = i_q;
  assign wr_j      = j_q;
  assign wr_data   = in_data;
  assign C_ri      = i_q;
  assign C_rj      = j_q;
  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  assign ij_last   = (i_q == Last) && (j_q == Last);

  // Slot freed by this cycle's pop counts as available, so a full-rate stream never bubbles.
  assign pending    = {1'b0, occ} + {2'b0, in_flight_q} - {2'b0, pop};
  assign issue      = (state == StDrain) && !all_issued_q && (pending < 3'd2);
  assign C_ren      = issue;
  assign drain_done = (state == StDrain) && all_issued_q && !in_flight_q &&
                      ((occ == 2'd0) || ((occ == 2'd1) && pop));

  always_comb begin
    j_nxt = (j_q == Last) ? '0 : j_q + 1'b1;
    i_nxt = i_q;
    if (j_q == Last) i_nxt = (i_q == Last) ? '0 : i_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= StIdle;
      i_q          <= '0;
      j_q          <= '0;
      tmo_q        <= '0;
      in_flight_q  <= 1'b0;
      all_issued_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      in_flight_q <= issue;
      unique case (state)
        StIdle: begin
          if (cmd_valid) begin
            state <= StLoadA;
            err_q <= 1'b0;
            i_q   <= '0;
            j_q   <= '0;
          end
        end
        StLoadA, StLoadB: begin
          if (beat) begin
            i_q <= i_nxt;
            j_q <= j_nxt;
            if (ij_last) state <= (state == StLoadA) ? StLoadB : StStart;
          end
        end
        StStart: begin
          state <= StCompute;
          tmo_q <= '0;
        end
        StCompute: begin
          if (done) begin
            state        <= StDrain;
            i_q          <= '0;
            j_q          <= '0;
            all_issued_q <= 1'b0;
          end else if (tmo_q == TmoLast) begin
            err_q <= 1'b1;
            state <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StDrain: begin
          if (issue) begin
            i_q <= i_nxt;
            j_q <= j_nxt;
            if (ij_last) all_issued_q <= 1'b1;
          end
          if (drain_done) state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

  mm_skid_buf #(
    .W (CW)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (in_flight_q),
    .push_data (C_rdata),
    .pop       (pop),
    .count     (occ),
    .head      (out_data)
  );

endmodule

// File: tb/tb_mm_job_seq.sv
// Directed bench for mm_job_seq at DIM=2: load, compute, drain, stall, timeout and reset cases.
module tb_mm_job_seq;

  localparam int DIM = 2;
  localparam int DW  = 8;
  localparam int AW  = 1;
  localparam int CW  = 17;
  localparam int TMO = 24;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, in_valid, in_ready;
  logic [DW-1:0] in_data, wr_data;
  logic          A_wen, B_wen, load_mem, start, done, C_ren;
  logic [AW-1:0] wr_i, wr_j, C_ri, C_rj;
  logic [CW-1:0] C_rdata, out_data;
  logic          out_valid, out_ready, busy, err;

  mm_job_seq #(
    .DIM (DIM),
    .DW  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .A_wen     (A_wen),
    .B_wen     (B_wen),
    .wr_i      (wr_i),
    .wr_j      (wr_j),
    .wr_data   (wr_data),
    .load_mem  (load_mem),
    .start     (start),
    .done      (done),
    .C_ren     (C_ren),
    .C_ri      (C_ri),
    .C_rj      (C_rj),
    .C_rdata   (C_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [DW-1:0] a_mem [4];
  logic [DW-1:0] b_mem [4];
  logic [CW-1:0] c_mem [4];
  logic [CW-1:0] rx [$];
  int            a_cnt, b_cnt, start_cnt, issued, popped;
  logic          prev_stall;
  logic [CW-1:0] prev_data;

  // C RAM model: one-cycle read latency, garbage on cycles without a read.
  always @(posedge clk) C_rdata <= C_ren ? c_mem[{C_ri, C_rj}] : 17'h1abcd;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (A_wen) begin
        check("a_addr", {30'd0, wr_i, wr_j}, a_cnt);
        a_mem[{wr_i, wr_j}] = wr_data;
        a_cnt++;
      end
      if (B_wen) begin
        check("b_addr", {30'd0, wr_i, wr_j}, b_cnt);
        b_mem[{wr_i, wr_j}] = wr_data;
        b_cnt++;
      end
      if (start) start_cnt++;
      if (C_ren) issued++;
      if (out_valid && out_ready) begin
        popped++;
        rx.push_back(out_data);
      end
      if (C_ren) check("reads_ahead", 32'(issued - popped <= 2), 1);
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_start"}, 32'(start), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_data"}, 32'(out_data), 0);
    check({tag, "_c_ren"}, 32'(C_ren), 0);
    check({tag, "_wen"}, 32'({A_wen, B_wen}), 0);
    check({tag, "_load_mem"}, 32'(load_mem), 0);
  endtask

  task automatic run_job(input bit gap, input bit rdy_toggle, input bit spurious,
                         input bit no_done, input int abort_after);
    logic [DW-1:0] vals [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    logic [CW-1:0] exp_c [4] = '{17'd19, 17'd22, 17'd43, 17'd50};
    int            pat [6] = '{1, 0, 0, 1, 0, 1};
    int            n;
    bit            finished;
    a_cnt = 0; b_cnt = 0; start_cnt = 0; issued = 0; popped = 0;
    rx.delete();
    out_ready = 1'b0;

    @(posedge clk); #1 cmd_valid = 1'b1;
    #1 check("cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    #1 check("err_cleared", 32'(err), 0);
    check("load_mem", 32'(load_mem), 1);

    for (int k = 0; k < 8; k++) begin
      if (gap) begin
        in_valid = 1'b0;
        in_data  = 8'hee;
        #1 check("gap_wen", 32'({A_wen, B_wen}), 0);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = vals[k];
      if (spurious && k == 5) begin
        cmd_valid = 1'b1;
        done      = 1'b1;
      end
      #1 check("in_ready", 32'(in_ready), 1);
      check("a_wen", 32'(A_wen), 32'(k < 4));
      check("b_wen", 32'(B_wen), 32'(k >= 4));
      check("wr_ij", 32'({wr_i, wr_j}), k % 4);
      if (spurious && k == 5) check("cmd_ready_busy", 32'(cmd_ready), 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      done      = 1'b0;
    end
    in_valid = 1'b0;
    #1 check("start", 32'(start), 1);
    check("start_load_mem", 32'(load_mem), 0);

    if (no_done) begin
      n = 0;
      for (int t = 0; t < 200; t++) begin
        @(posedge clk); #2;
        if (!busy) break;
        n++;
      end
      check("tmo_cycles", n, TMO);
      check("tmo_err", 32'(err), 1);
      check("tmo_idle", 32'(cmd_ready), 1);
      check("tmo_starts", start_cnt, 1);
      return;
    end

    repeat (3) @(posedge clk);
    #1 check("compute_busy", 32'(busy), 1);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        c_mem[r * 2 + c] = CW'(a_mem[r * 2] * b_mem[c] + a_mem[r * 2 + 1] * b_mem[2 + c]);
    done = 1'b1;
    @(posedge clk); #1 done = 1'b0;

    finished = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      out_ready = rdy_toggle ? pat[cyc % 6] != 0 : 1'b1;
      @(posedge clk); #1;
      if (abort_after > 0 && rx.size() >= abort_after) begin
        reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        #1 reset = 1'b0;
        out_ready = 1'b0;
        return;
      end
      if (rx.size() == 4 && !busy) begin
        finished = 1'b1;
        break;
      end
    end
    out_ready = 1'b0;
    check("drain_finished", 32'(finished), 1);
    check("rx_count", rx.size(), 4);
    for (int k = 0; k < 4; k++)
      check("out_data", (k < rx.size()) ? 32'(rx[k]) : 32'hdeadbeef, 32'(exp_c[k]));
    for (int k = 0; k < 4; k++) begin
      check("a_mem", 32'(a_mem[k]), k + 1);
      check("b_mem", 32'(b_mem[k]), k + 5);
    end
    check("start_count", start_cnt, 1);
    check("a_beats", a_cnt, 4);
    check("b_beats", b_cnt, 4);
    check("end_idle", 32'(cmd_ready), 1);
    check("end_err", 32'(err), 0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; in_valid = 1'b0; in_data = '0;
    done = 1'b0; out_ready = 1'b0;
    for (int k = 0; k < 4; k++) c_mem[k] = '0;
    #12 check_reset_outputs("reset");
    #1 reset = 1'b0;

    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);  // straight job
    run_job(1'b0, 1'b1, 1'b0, 1'b0, 0);  // out_ready toggling
    run_job(1'b1, 1'b0, 1'b0, 1'b0, 0);  // in_valid gaps
    run_job(1'b0, 1'b0, 1'b0, 1'b1, 0);  // timeout
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);  // err cleared by next job
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 2);  // reset mid-drain
    run_job(1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_job(1'b0, 1'b0, 1'b1, 1'b0, 0);  // spurious cmd/done in LOAD_B

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
